pc_sequencer: RTL and testbench

//  Program-counter register and next-PC selector for the fetch stage.

---
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage sequencer bus: redirect/stall/halt requests in, fetch address and status out.
// The slave side is the sequencer; the master side is whatever drives the fetch control.
interface pc_sequencer_if #(
  parameter int MSB = 32
);
  logic           stall;
  logic           branch_taken;
  logic [MSB-1:0] branch_addr;
  logic           jump;
  logic [MSB-1:0] jump_addr;
  logic           halt;
  logic [MSB-1:0] pc;
  logic [MSB-1:0] next_pc;
  logic           flush;
  logic           fetch_valid;
  logic           halted;
  logic [1:0]     state_dbg;

  // Request inputs are level-sampled on every rising edge; there is no
  // valid/ready handshake. The sequencer acknowledges a redirect only
  // through a one-cycle flush pulse, issued when the redirect is applied.
  modport master (
    output stall, branch_taken, branch_addr, jump, jump_addr, halt,
    input  pc, next_pc, flush, fetch_valid, halted, state_dbg
  );

  modport slave (
    input  stall, branch_taken, branch_addr, jump, jump_addr, halt,
    output pc, next_pc, flush, fetch_valid, halted, state_dbg
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC selector for the fetch stage, with a
// one-entry pending-redirect buffer that holds a redirect arriving while stalled.
module pc_sequencer #(
  parameter int             MSB      = 32,
  parameter logic [MSB-1:0] RESET_PC = '0,
  parameter int unsigned    INC      = 4
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t         state;
  logic [MSB-1:0] pc_q;
  logic           flush_q;
  logic           fetch_valid_q;
  logic           halted_q;
  logic           pend_v;
  logic [MSB-1:0] pend_addr;

  logic           redir_v;
  logic [MSB-1:0] redir_addr;
  logic [MSB-1:0] pc_inc;

  assign pc_inc = pc_q + MSB'(INC);

  // Priority: branch (oldest instruction), then pending, then jump.
  // Reused as the stalled-capture rule: a branch overwrites pending, while a
  // jump with pending already full selects pending and so leaves it unchanged.
  always_comb begin
    redir_v    = bus.branch_taken | pend_v | bus.jump;
    redir_addr = pc_q;
    if (bus.branch_taken)  redir_addr = bus.branch_addr;
    else if (pend_v)       redir_addr = pend_addr;
    else if (bus.jump)     redir_addr = bus.jump_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      pend_v        <= 1'b0;
      pend_addr     <= '0;
    end else begin
      case (state)
        RUN, HOLD: begin
          if (!fetch_valid_q) begin
            // First cycle out of reset only validates RESET_PC; inputs are ignored.
            fetch_valid_q <= 1'b1;
            flush_q       <= 1'b0;
          end else if (bus.stall) begin
            flush_q <= 1'b0;
            state   <= HOLD;
            if (redir_v) begin
              pend_v    <= 1'b1;
              pend_addr <= redir_addr;
            end
          end else begin
            pend_v <= 1'b0;
            if (redir_v) begin
              pc_q    <= redir_addr;
              flush_q <= 1'b1;
              state   <= RUN;
            end else if (bus.halt) begin
              flush_q       <= 1'b0;
              fetch_valid_q <= 1'b0;
              halted_q      <= 1'b1;
              state         <= HALTED;
            end else begin
              pc_q    <= pc_inc;
              flush_q <= 1'b0;
              state   <= RUN;
            end
          end
        end
        HALTED: begin
          flush_q <= 1'b0;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.next_pc     = pc_inc;
  assign bus.flush       = flush_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.halted      = halted_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential fetch, redirects,
// stalled redirect capture, halt, wrap-around and reset during stall.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  pc_sequencer_if #(.MSB(32)) bus ();

  pc_sequencer #(.MSB(32), .RESET_PC(32'h0), .INC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr  = 32'h0;
    bus.jump         = 1'b0;
    bus.jump_addr    = 32'h0;
    bus.halt         = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_pc, input logic e_flush,
                           input logic e_fv, input logic e_halted);
    check({tag, ".pc"},          bus.pc,          e_pc);
    check({tag, ".next_pc"},     bus.next_pc,     e_pc + 32'd4);
    check({tag, ".flush"},       32'(bus.flush),       32'(e_flush));
    check({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(e_fv));
    check({tag, ".halted"},      32'(bus.halted),      32'(e_halted));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear_inputs();
    reset = 1'b1;

    // 1: reset then sequential fetch
    tick();
    tick();
    check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset.state", 32'(bus.state_dbg), 32'(ST_RUN));
    reset = 1'b0;
    tick();
    check_out("first", 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("seq4", 32'h4, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("seq8", 32'h8, 1'b0, 1'b1, 1'b0);

    // 2: taken branch at pc=8
    bus.branch_taken = 1'b1; bus.branch_addr = 32'h40;
    tick();
    check_out("br40", 32'h40, 1'b1, 1'b1, 1'b0);
    clear_inputs();
    tick();
    check_out("br44", 32'h44, 1'b0, 1'b1, 1'b0);

    // 3: three-cycle stall with branch in stall cycle 2
    bus.stall = 1'b1;
    tick();
    check_out("stall1", 32'h44, 1'b0, 1'b1, 1'b0);
    check("stall1.state", 32'(bus.state_dbg), 32'(ST_HOLD));
    bus.branch_taken = 1'b1; bus.branch_addr = 32'h80;
    tick();
    check_out("stall2", 32'h44, 1'b0, 1'b1, 1'b0);
    bus.branch_taken = 1'b0;
    tick();
    check_out("stall3", 32'h44, 1'b0, 1'b1, 1'b0);
    bus.stall = 1'b0;
    tick();
    check_out("pend80", 32'h80, 1'b1, 1'b1, 1'b0);
    check("pend80.state", 32'(bus.state_dbg), 32'(ST_RUN));
    tick();
    check_out("pend84", 32'h84, 1'b0, 1'b1, 1'b0);

    // 4: branch beats jump in the same cycle
    bus.branch_taken = 1'b1; bus.branch_addr = 32'h100;
    bus.jump = 1'b1;         bus.jump_addr   = 32'h200;
    tick();
    check_out("prio_same", 32'h100, 1'b1, 1'b1, 1'b0);
    clear_inputs();
    tick();
    check_out("prio_same_inc", 32'h104, 1'b0, 1'b1, 1'b0);

    // 4b: under stall, jump captured first, later branch overwrites it
    bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_addr = 32'h200;
    tick();
    check_out("hold_jmp", 32'h104, 1'b0, 1'b1, 1'b0);
    bus.jump = 1'b0; bus.branch_taken = 1'b1; bus.branch_addr = 32'h100;
    tick();
    check_out("hold_br", 32'h104, 1'b0, 1'b1, 1'b0);
    clear_inputs();
    tick();
    check_out("hold_rel", 32'h100, 1'b1, 1'b1, 1'b0);

    // 4c: pending jump is not overwritten by a later jump and beats a live jump
    bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_addr = 32'h300;
    tick();
    bus.jump_addr = 32'h500;
    tick();
    check_out("hold_jj", 32'h100, 1'b0, 1'b1, 1'b0);
    bus.stall = 1'b0; bus.jump_addr = 32'h400;
    tick();
    check_out("pend_vs_jump", 32'h300, 1'b1, 1'b1, 1'b0);
    clear_inputs();

    // 5: halt together with a redirect: redirect wins, halt dropped
    bus.halt = 1'b1; bus.jump = 1'b1; bus.jump_addr = 32'h10;
    tick();
    check_out("halt_redir", 32'h10, 1'b1, 1'b1, 1'b0);
    bus.jump = 1'b0;
    tick();
    check_out("halt", 32'h10, 1'b0, 1'b0, 1'b1);
    check("halt.state", 32'(bus.state_dbg), 32'(ST_HALTED));
    bus.halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.branch_taken = i[0];
      bus.branch_addr  = 32'h900 + 32'(i);
      bus.stall        = i[1];
      tick();
      check_out("halted_hold", 32'h10, 1'b0, 1'b0, 1'b1);
    end
    clear_inputs();
    reset = 1'b1;
    tick();
    check_out("halt_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_out("halt_rerun", 32'h0, 1'b0, 1'b1, 1'b0);

    // 6: jump to top of address space, then wrap
    bus.jump = 1'b1; bus.jump_addr = 32'hFFFF_FFFC;
    tick();
    check_out("wrap_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    check("wrap_next", bus.next_pc, 32'h0);
    clear_inputs();
    tick();
    check_out("wrap_zero", 32'h0, 1'b0, 1'b1, 1'b0);

    // 6b: reset during stall with a captured redirect discards it
    tick();
    check_out("pre_stall", 32'h4, 1'b0, 1'b1, 1'b0);
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_addr = 32'h700;
    tick();
    check_out("cap700", 32'h4, 1'b0, 1'b1, 1'b0);
    bus.branch_taken = 1'b0;
    reset = 1'b1;
    tick();
    check_out("rst_stall", 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_stall.state", 32'(bus.state_dbg), 32'(ST_RUN));
    reset = 1'b0; bus.stall = 1'b0;
    tick();
    check_out("rst_rel", 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("rst_no_pend", 32'h4, 1'b0, 1'b1, 1'b0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
